snes_host_bus_master: RTL and testbench
=======================================

Name: snes_host_bus_master

Overview:
- Initiator on the SNES host bus (ha, hd, r, w, romsel) facing the SuperFX top level, which is the responder.
- Converts a simple valid/ready command interface into correctly sequenced SNES read/write bus cycles, and returns read data through a response strobe.
- Used as the host-side stimulus engine in system benches and as the bus front-end of the FPGA host harness.
- Runs entirely on clk_21mhz; one transaction in flight at a time.

Parameters:
- SETUP_CYC, 2, cycles ha is stable before the r/w strobe asserts (1..15).
- STROBE_CYC, 6, cycles r or w is held low (SlowROM timing, 1..15).
- HOLD_CYC, 1, cycles ha and hd_out stay stable after the strobe deasserts (0..15).
- FAST_STROBE_CYC, 4, strobe length for FastROM-region accesses; used only with HOST_FASTROM_EN (1..15).

Ports:
- clk_21mhz  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command; high only in IDLE.
- cmd_write  input  1  1 = write cycle, 0 = read cycle.
- cmd_addr  input  24  host address (bank:offset).
- cmd_wdata  input  8  write data.
- rsp_valid  output  1  one-cycle pulse when a transaction completes (reads and writes).
- rsp_rdata  output  8  read data, valid with rsp_valid; 8'h00 for writes.
- ha  output  24  host address bus.
- hd_out  output  8  host data driven toward the SuperFX.
- hd_oe  output  1  1 while hd_out is driven (write cycles only).
- hd_in  input  8  data returned by the SuperFX.
- r  output  1  read strobe, active low.
- w  output  1  write strobe, active low.
- romsel  output  1  ROM select, active low.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: cmd_ready=0 during reset and 1 afterwards (IDLE); rsp_valid=0; rsp_rdata=0; ha=0; hd_out=0; hd_oe=0; r=1; w=1; romsel=1; busy=0.
- Reset mid-transaction: everything returns to reset values on the next edge, and no rsp_valid is issued.
- FSM states and transitions:
  - IDLE: on cmd_valid && cmd_ready, latch addr, wdata and write, then go to SETUP.
  - SETUP: counts SETUP_CYC, then go to STROBE.
  - STROBE: counts the strobe length, then go to HOLD.
  - HOLD: counts HOLD_CYC, then go to RESP. If HOLD_CYC=0, HOLD is skipped and STROBE goes directly to RESP.
  - RESP: one cycle; rsp_valid=1, then back to IDLE.
- Signal timing within a transaction:
  - ha is registered from the latched address on entry to SETUP and held through HOLD. It returns to 0 in RESP/IDLE.
  - romsel is decoded from the latched address and is valid from SETUP through HOLD. It is 0 when bank is in 40-7D or C0-FF (any offset). It is also 0 when offset[15]=1 and bank is not 7E or 7F. Otherwise it is 1.
  - Write: hd_oe=1 and hd_out=wdata from SETUP through HOLD; w=0 only in STROBE.
  - Read: r=0 only in STROBE; hd_in is sampled on the last STROBE cycle into rsp_rdata.
- Strobe overlap: r and w are never low simultaneously, and a strobe is never low while ha is changing.
- Throughput: total latency from accept to rsp_valid is SETUP_CYC + strobe + HOLD_CYC + 1 cycles. The next command can be accepted the cycle after RESP.
- Counters: one 4-bit down-counter reloaded at each state entry. Parameter value 0 for SETUP_CYC or STROBE_CYC is illegal and is treated as 1.
- Command capture: cmd_* inputs are ignored outside the IDLE accept cycle, so changing them mid-transaction has no effect.

Optional Feature:
- HOST_FASTROM_EN defined:
  - Adds an input memsel (1 bit, reset-sampled as 0), mirroring the SNES MEMSEL register.
  - When memsel=1 and latched bank[7]=1 and romsel decodes 0, STROBE lasts FAST_STROBE_CYC.
- HOST_FASTROM_EN undefined: no memsel port; every access uses STROBE_CYC.

Decomposition:
- Shared package (fig_04_pkg): FSM state encoding (IDLE, SETUP, STROBE, HOLD, RESP), the WRAM bank constants 8'h7E/8'h7F, and the romsel decode as a function.
- One natural sub-module: snes_romsel_decode (combinational, 24-bit address in, romsel out). It is reused by the cartridge-side address decoder.

Test Plan:
- Write, defaults: cmd_addr=24'h003038, wdata=8'h5A → ha=003038 for 9 cycles, w low exactly 6 cycles, hd_out=5A with hd_oe=1, romsel=1, rsp_valid 10 cycles after accept.
- Read: cmd_addr=24'h00303A, hd_in=8'hC3 during the last strobe cycle → rsp_rdata=C3, r low 6 cycles, w stays 1.
- Romsel decode: addresses 008000, 400000, 7E8000, 7F0000, C01234 → romsel 0, 0, 1, 1, 0 respectively.
- Back-to-back: cmd_valid held high with two commands → second accepted the cycle after the first rsp_valid; cmd_ready low throughout the first transaction.
- Reset mid-STROBE of a write: reset asserted → next edge w=1, hd_oe=0, ha=0; no rsp_valid; cmd_ready=1 after reset releases.
- HOST_FASTROM_EN, memsel=1, read at 808000 → r low 4 cycles; same read at 008000 → 6 cycles.

Source files
------------

// File: rtl/fig_04_pkg.sv
// Shared types and helpers for the SNES host bus master and cartridge-side decoding.
package fig_04_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold,
        StResp
    } bus_state_e;

    localparam logic [7:0] WramBankLo = 8'h7E;
    localparam logic [7:0] WramBankHi = 8'h7F;

    // Active-low ROM select for a 24-bit bank:offset address.
    function automatic logic romsel_decode(input logic [23:0] addr);
        logic [7:0] bank;
        bank = addr[23:16];
        if ((bank >= 8'h40 && bank <= 8'h7D) || bank >= 8'hC0) begin
            return 1'b0;
        end
        if (addr[15] && bank != WramBankLo && bank != WramBankHi) begin
            return 1'b0;
        end
        return 1'b1;
    endfunction

    // Down-counter reload value for an n-cycle phase; 0 is treated as 1.
    function automatic logic [3:0] cyc_load(input int unsigned n);
        if (n <= 1) begin
            return 4'd0;
        end
        return 4'(n - 1);
    endfunction

endpackage

// File: rtl/snes_romsel_decode.sv
// Combinational ROM-select decode, shared with the cartridge-side address decoder.
module snes_romsel_decode
    import fig_04_pkg::*;
(
    input  logic [23:0] addr,
    output logic        romsel
);

    assign romsel = romsel_decode(addr);

endmodule

// File: rtl/snes_host_bus_master.sv
// SNES host bus initiator: sequences one read/write bus cycle per accepted command.
// Define HOST_FASTROM_EN to add the memsel input and the shorter FastROM strobe.
module snes_host_bus_master
    import fig_04_pkg::*;
#(
    parameter int unsigned SETUP_CYC       = 2,
    parameter int unsigned STROBE_CYC      = 6,
    parameter int unsigned HOLD_CYC        = 1,
    parameter int unsigned FAST_STROBE_CYC = 4
) (
    input  logic        clk_21mhz,
    input  logic        reset,
`ifdef HOST_FASTROM_EN
    input  logic        memsel,
`endif
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [23:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic [23:0] ha,
    output logic [7:0]  hd_out,
    output logic        hd_oe,
    input  logic [7:0]  hd_in,
    output logic        r,
    output logic        w,
    output logic        romsel,
    output logic        busy
);

    localparam logic [3:0] SetupLoad  = cyc_load(SETUP_CYC);
    localparam logic [3:0] StrobeLoad = cyc_load(STROBE_CYC);
    localparam logic [3:0] FastLoad   = cyc_load(FAST_STROBE_CYC);
    localparam logic [3:0] HoldLoad   = cyc_load(HOLD_CYC);

    bus_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [23:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        write_q, write_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        romsel_dec;
    logic        fast_sel;
    logic [3:0]  strobe_load;
    logic        active;

    snes_romsel_decode u_romsel_decode (
        .addr   (addr_q),
        .romsel (romsel_dec)
    );

`ifdef HOST_FASTROM_EN
    logic memsel_q;

    always_ff @(posedge clk_21mhz) begin
        if (reset) begin
            memsel_q <= 1'b0;
        end else begin
            memsel_q <= memsel;
        end
    end

    assign fast_sel = memsel_q && addr_q[23] && !romsel_dec;
`else
    assign fast_sel = 1'b0;
`endif

    assign strobe_load = fast_sel ? FastLoad : StrobeLoad;

    always_ff @(posedge clk_21mhz) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    write_d = cmd_write;
                    rdata_d = '0;
                    cnt_d   = SetupLoad;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == 4'd0) begin
                    cnt_d   = strobe_load;
                    state_d = StStrobe;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StStrobe: begin
                if (cnt_q == 4'd0) begin
                    // Read data is captured on the final strobe cycle.
                    if (!write_q) begin
                        rdata_d = hd_in;
                    end
                    cnt_d   = HoldLoad;
                    state_d = (HOLD_CYC == 0) ? StResp : StHold;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StHold: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        active    = (state_q == StSetup) || (state_q == StStrobe) || (state_q == StHold);
        busy      = (state_q != StIdle);
        cmd_ready = (state_q == StIdle) && !reset;
        ha        = active ? addr_q : '0;
        hd_oe     = active && write_q;
        hd_out    = hd_oe ? wdata_q : '0;
        w         = !((state_q == StStrobe) && write_q);
        r         = !((state_q == StStrobe) && !write_q);
        romsel    = active ? romsel_dec : 1'b1;
        rsp_valid = (state_q == StResp);
        rsp_rdata = rdata_q;
    end

endmodule

// File: tb/tb_snes_host_bus_master.sv
// Directed bench for snes_host_bus_master: vector table plus reset / back-to-back sequences.
module tb_snes_host_bus_master;

    localparam int unsigned SetupCyc  = 2;
    localparam int unsigned StrobeCyc = 6;
    localparam int unsigned HoldCyc   = 1;
    localparam int unsigned FastCyc   = 4;

    logic        clk_21mhz = 1'b0;
    logic        reset     = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [23:0] cmd_addr  = '0;
    logic [7:0]  cmd_wdata = '0;
    logic [7:0]  hd_in     = '0;
    logic        cmd_ready, rsp_valid, hd_oe, r, w, romsel, busy;
    logic [7:0]  rsp_rdata, hd_out;
    logic [23:0] ha;
`ifdef HOST_FASTROM_EN
    logic        memsel = 1'b0;
`endif

    snes_host_bus_master #(
        .SETUP_CYC       (SetupCyc),
        .STROBE_CYC      (StrobeCyc),
        .HOLD_CYC        (HoldCyc),
        .FAST_STROBE_CYC (FastCyc)
    ) dut (
        .clk_21mhz (clk_21mhz),
        .reset     (reset),
`ifdef HOST_FASTROM_EN
        .memsel    (memsel),
`endif
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ha        (ha),
        .hd_out    (hd_out),
        .hd_oe     (hd_oe),
        .hd_in     (hd_in),
        .r         (r),
        .w         (w),
        .romsel    (romsel),
        .busy      (busy)
    );

    always #5 clk_21mhz = ~clk_21mhz;

    typedef struct {
        logic        write;
        logic [23:0] addr;
        logic [7:0]  data;        // write data, or hd_in returned for reads
        logic        exp_romsel;
        logic [7:0]  exp_rdata;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_21mhz);
        #1;
    endtask

    // Issue one command from IDLE and check the whole bus cycle up to the response.
    task automatic run_txn(input vec_t v, input int exp_strobe, input string tag);
        int rsp_cyc = 0, w_low = 0, r_low = 0, ha_ok = 0, oe_cyc = 0;
        int hd_bad = 0, rs_bad = 0, ovl = 0, rdy_bad = 0;
        int active_len;
        logic [7:0] rdata = '0;
        active_len = SetupCyc + exp_strobe + HoldCyc;
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.data;
        hd_in     = 8'hEE;
        check({tag, " accept_ready"}, cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        cmd_write = ~v.write;
        cmd_addr  = ~v.addr;
        cmd_wdata = ~v.data;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (rsp_valid) begin
                rsp_cyc = cyc;
                rdata   = rsp_rdata;
                break;
            end
            if (!w) w_low++;
            if (!r) r_low++;
            if (!r && !w) ovl++;
            if (ha === v.addr) ha_ok++;
            if (hd_oe) begin
                oe_cyc++;
                if (hd_out !== v.data) hd_bad++;
            end
            if (romsel !== v.exp_romsel) rs_bad++;
            if (cmd_ready) rdy_bad++;
            hd_in = (!r && r_low == exp_strobe) ? v.data : 8'hEE;
            tick();
        end
        hd_in = 8'hEE;
        check({tag, " latency"}, rsp_cyc, active_len + 1);
        check({tag, " ha_cycles"}, ha_ok, active_len);
        check({tag, " w_low"}, w_low, v.write ? exp_strobe : 0);
        check({tag, " r_low"}, r_low, v.write ? 0 : exp_strobe);
        check({tag, " strobe_overlap"}, ovl, 0);
        check({tag, " hd_oe_cycles"}, oe_cyc, v.write ? active_len : 0);
        check({tag, " hd_out_bad"}, hd_bad, 0);
        check({tag, " romsel_bad"}, rs_bad, 0);
        check({tag, " ready_busy"}, rdy_bad, 0);
        check({tag, " rsp_rdata"}, rdata, v.exp_rdata);
        tick();
        check({tag, " idle_ready"}, cmd_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rsp_cyc;
        int rdy_bad;
        int ha_bad;
        int seen;
        logic [7:0] rdata;

        vecs[0] = '{1'b0, 24'h00303A, 8'hC3, 1'b1, 8'hC3};
        vecs[1] = '{1'b1, 24'h003038, 8'h5A, 1'b1, 8'h00};
        vecs[2] = '{1'b0, 24'h008000, 8'h11, 1'b0, 8'h11};
        vecs[3] = '{1'b0, 24'h400000, 8'h22, 1'b0, 8'h22};
        vecs[4] = '{1'b1, 24'h7E8000, 8'h33, 1'b1, 8'h00};
        vecs[5] = '{1'b0, 24'h7F0000, 8'h44, 1'b1, 8'h44};
        vecs[6] = '{1'b0, 24'hC01234, 8'h55, 1'b0, 8'h55};

        // Reset state
        tick();
        tick();
        check("rst cmd_ready", cmd_ready, 0);
        check("rst busy", busy, 0);
        check("rst r", r, 1);
        check("rst w", w, 1);
        check("rst romsel", romsel, 1);
        check("rst ha", ha, 0);
        check("rst hd_oe", hd_oe, 0);
        check("rst hd_out", hd_out, 0);
        check("rst rsp_valid", rsp_valid, 0);
        check("rst rsp_rdata", rsp_rdata, 0);
        reset = 1'b0;
        tick();
        check("post_rst cmd_ready", cmd_ready, 1);

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i], StrobeCyc, $sformatf("vec%0d", i));
        end

        // Back-to-back: valid held high, second command waits for the first response.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 24'h00303A;
        hd_in     = 8'h77;
        check("b2b accept_a", cmd_ready, 1);
        tick();
        cmd_write = 1'b1;
        cmd_addr  = 24'h7E8000;
        cmd_wdata = 8'h99;
        rsp_cyc = 0;
        rdy_bad = 0;
        ha_bad  = 0;
        rdata   = '0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (rsp_valid) begin
                rsp_cyc = cyc;
                rdata   = rsp_rdata;
                break;
            end
            if (cmd_ready) rdy_bad++;
            if (ha !== 24'h00303A) ha_bad++;
            tick();
        end
        check("b2b a_latency", rsp_cyc, SetupCyc + StrobeCyc + HoldCyc + 1);
        check("b2b a_ready_low", rdy_bad, 0);
        check("b2b a_ha_held", ha_bad, 0);
        check("b2b a_rdata", rdata, 8'h77);
        tick();
        check("b2b idle_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check("b2b b_busy", busy, 1);
        check("b2b b_ha", ha, 24'h7E8000);
        check("b2b b_hd_out", hd_out, 8'h99);
        rsp_cyc = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (rsp_valid) begin
                rsp_cyc = cyc;
                rdata   = rsp_rdata;
                break;
            end
            tick();
        end
        check("b2b b_latency", rsp_cyc, SetupCyc + StrobeCyc + HoldCyc + 1);
        check("b2b b_rdata", rdata, 8'h00);
        tick();

        // Reset in the middle of a write strobe.
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 24'h003038;
        cmd_wdata = 8'h5A;
        tick();
        cmd_valid = 1'b0;
        seen = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (!w) begin
                seen = 1;
                break;
            end
            tick();
        end
        check("rst_mid strobe_seen", seen, 1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rst_mid w", w, 1);
        check("rst_mid r", r, 1);
        check("rst_mid hd_oe", hd_oe, 0);
        check("rst_mid ha", ha, 0);
        check("rst_mid busy", busy, 0);
        check("rst_mid romsel", romsel, 1);
        check("rst_mid ready_in_reset", cmd_ready, 0);
        reset = 1'b0;
        seen = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            tick();
            if (rsp_valid) seen++;
        end
        check("rst_mid no_rsp", seen, 0);
        check("rst_mid ready_after", cmd_ready, 1);

`ifdef HOST_FASTROM_EN
        memsel = 1'b1;
        tick();
        run_txn('{1'b0, 24'h808000, 8'hAB, 1'b0, 8'hAB}, FastCyc, "fast808000");
        run_txn('{1'b0, 24'h008000, 8'hCD, 1'b0, 8'hCD}, StrobeCyc, "slow008000");
        memsel = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
